phase_decode: RTL and testbench

PHASE_DECODE -- requirements
Module: phase_decode

---
 rtl/phase_decode.sv | 149 ++++++++++++++
 tb/tb_phase_decode.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_decode.sv
// Phase decoder: samples the four phase clocks, recognises the two-hot
// phase patterns and locks once LOCK_CNT patterns arrive in correct cyclic
// order. Loss of lock is flagged with a one-cycle pulse and counted.
module phase_decode #(
  parameter int LOCK_CNT = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_FT,
  input  logic       CLK_DC,
  input  logic       CLK_EX,
  input  logic       CLK_WB,
  input  logic       CLR_ERR,
  output logic [1:0] PHASE,
  output logic       EN_FT,
  output logic       EN_DC,
  output logic       EN_EX,
  output logic       EN_WB,
  output logic       LOCKED,
  output logic       SYNC_ERR,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCK} state_t;

  localparam logic [2:0] LC = LOCK_CNT[2:0];

  logic [3:0] r_s;
  state_t     r_state;
  logic [2:0] r_g;
  logic [1:0] r_l;
  logic [1:0] r_phase;
  logic [3:0] r_en;
  logic       r_locked;
  logic       r_sync_err;
  logic [7:0] r_err_cnt;

  logic       w_valid;
  logic [1:0] w_phase;
  logic [1:0] w_l_next;
  logic [2:0] w_g_inc;
  logic       w_succ;
  logic       w_loss;

  // Register the raw phase clocks once; everything downstream uses r_s only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_s <= 4'b0000;
    else       r_s <= {CLK_FT, CLK_DC, CLK_EX, CLK_WB};
  end

  // Map the sampled pattern to a phase index; anything else is invalid.
  always_comb begin
    w_valid = 1'b0;
    w_phase = 2'd0;
    case (r_s)
      4'b1001: begin w_valid = 1'b1; w_phase = 2'd0; end
      4'b1100: begin w_valid = 1'b1; w_phase = 2'd1; end
      4'b0110: begin w_valid = 1'b1; w_phase = 2'd2; end
      4'b0011: begin w_valid = 1'b1; w_phase = 2'd3; end
      default: begin w_valid = 1'b0; w_phase = 2'd0; end
    endcase
  end

  // The 2-bit add wraps phase 3 back to phase 0.
  assign w_l_next = r_l + 2'd1;
  assign w_g_inc  = r_g + 3'd1;
  assign w_succ   = w_valid && (w_phase == w_l_next);
  assign w_loss   = (r_state == ST_LOCK) && !w_succ;

  // Acquisition/lock FSM with registered phase, enable and lock outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_g        <= 3'd0;
      r_l        <= 2'd0;
      r_phase    <= 2'd0;
      r_en       <= 4'b0000;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_locked   <= 1'b0;
      r_en       <= 4'b0000;
      r_phase    <= 2'd0;
      r_sync_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state <= ST_ACQ;
            r_g     <= 3'd1;
            r_l     <= w_phase;
          end else begin
            r_g <= 3'd0;
          end
        end
        ST_ACQ: begin
          if (!w_valid) begin
            r_state <= ST_IDLE;
            r_g     <= 3'd0;
          end else if (w_succ) begin
            r_g <= w_g_inc;
            r_l <= w_phase;
            if (w_g_inc == LC) begin
              r_state  <= ST_LOCK;
              r_locked <= 1'b1;
              r_phase  <= w_phase;
              r_en     <= 4'b0001 << w_phase;
            end
          end else begin
            r_g <= 3'd1;
            r_l <= w_phase;
          end
        end
        ST_LOCK: begin
          if (w_succ) begin
            r_l      <= w_phase;
            r_locked <= 1'b1;
            r_phase  <= w_phase;
            r_en     <= 4'b0001 << w_phase;
          end else begin
            r_state    <= ST_IDLE;
            r_g        <= 3'd0;
            r_sync_err <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_g     <= 3'd0;
        end
      endcase
    end
  end

  // Saturating loss-of-lock counter; a clear coinciding with a loss leaves 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                              r_err_cnt <= 8'd0;
    else if (CLR_ERR)                       r_err_cnt <= w_loss ? 8'd1 : 8'd0;
    else if (w_loss && r_err_cnt != 8'hFF)  r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign PHASE    = r_phase;
  assign EN_FT    = r_en[0];
  assign EN_DC    = r_en[1];
  assign EN_EX    = r_en[2];
  assign EN_WB    = r_en[3];
  assign LOCKED   = r_locked;
  assign SYNC_ERR = r_sync_err;
  assign ERR_CNT  = r_err_cnt;

endmodule

// File: tb/tb_phase_decode.sv
// Scoreboard bench for phase_decode: the driver pushes expected outputs
// from a sequence-level reference model, a monitor pops and compares.
module tb_phase_decode;

  localparam int LOCK_CNT = 4;
  localparam logic [3:0] PAT [4] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ft = 1'b0, dc = 1'b0, ex = 1'b0, wb = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] phase;
  logic       en_ft, en_dc, en_ex, en_wb;
  logic       locked, sync_err;
  logic [7:0] err_cnt;

  phase_decode #(.LOCK_CNT(LOCK_CNT)) dut (
    .CLK(clk), .RESET(rst),
    .CLK_FT(ft), .CLK_DC(dc), .CLK_EX(ex), .CLK_WB(wb),
    .CLR_ERR(clr),
    .PHASE(phase),
    .EN_FT(en_ft), .EN_DC(en_dc), .EN_EX(en_ex), .EN_WB(en_wb),
    .LOCKED(locked), .SYNC_ERR(sync_err), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    bit         locked;
    logic [1:0] phase;
    logic [3:0] en;
    bit         sync;
    int         err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   ecnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model state
  int   m_run = 0;
  bit   m_locked = 1'b0;
  int   m_last = 0;
  int   m_err = 0;
  logic [3:0] p_prev = 4'b0000;
  bit   clr_pend = 1'b0;
  int   cur = 3;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, ecnt, act, exp);
    end
  endtask

  function automatic int dec(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p === PAT[i]) return i;
    return -1;
  endfunction

  // One decoded sample: run length of correctly ordered patterns drives lock.
  function automatic exp_t model(input logic [3:0] p, input bit c);
    exp_t e;
    int   v;
    bit   loss;
    loss = 1'b0;
    v = dec(p);
    if (m_locked) begin
      if (v >= 0 && v == (m_last + 1) % 4) m_last = v;
      else begin m_locked = 1'b0; m_run = 0; loss = 1'b1; end
    end else if (v < 0) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && v == (m_last + 1) % 4) m_run++;
      else m_run = 1;
      m_last = v;
      if (m_run == LOCK_CNT) m_locked = 1'b1;
    end
    if (c) m_err = loss ? 1 : 0;
    else if (loss && m_err < 255) m_err++;
    e.tgt    = 0;
    e.locked = m_locked;
    e.phase  = m_locked ? 2'(m_last) : 2'd0;
    e.en     = m_locked ? 4'(1 << m_last) : 4'd0;
    e.sync   = loss;
    e.err    = m_err;
    return e;
  endfunction

  // clr_now takes effect on the edge that decodes pattern p.
  task automatic step(input logic [3:0] p, input bit clr_now);
    exp_t e;
    @(negedge clk);
    clr = clr_pend;
    {ft, dc, ex, wb} = p;
    e = model(p_prev, clr_pend);
    e.tgt = ecnt + 1;
    q.push_back(e);
    p_prev = p;
    clr_pend = clr_now;
    if (dec(p) >= 0) cur = dec(p);
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) step(PAT[(cur + 1) % 4], 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_en"}, {en_wb, en_ex, en_dc, en_ft}, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_sync"}, sync_err, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
  endtask

  task automatic model_reset();
    m_run = 0; m_locked = 1'b0; m_last = 0; m_err = 0;
    p_prev = 4'b0000; clr_pend = 1'b0; cur = 3;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      while (q.size() > 0 && q[0].tgt < ecnt) begin
        n_chk++; n_fail++;
        $display("FAIL missed_slot: expected edge %0d, now %0d", q[0].tgt, ecnt);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].tgt == ecnt) begin
        mon_e = q.pop_front();
        chk("locked", locked, mon_e.locked);
        chk("en", {en_wb, en_ex, en_dc, en_ft}, mon_e.en);
        if (mon_e.locked) chk("phase", phase, mon_e.phase);
        chk("sync_err", sync_err, mon_e.sync);
        chk("err_cnt", err_cnt, mon_e.err);
      end
    end
  end

  initial begin
    int p;
    int guard;
    repeat (3) @(negedge clk);
    chk_reset("reset_hold");
    rst = 1'b0;
    model_reset();

    // normal sequence from reset
    run_seq(12);
    // drop to 0000 while locked at phase 1, then relock
    run_seq(2);
    step(4'b0000, 1'b0);
    run_seq(6);
    // skipped phase while locked
    step(PAT[0], 1'b0);
    step(PAT[2], 1'b0);
    run_seq(6);
    // out-of-order pattern during acquisition with G=3
    step(4'b0000, 1'b0);
    cur = 2;
    run_seq(3);
    step(PAT[1], 1'b0);
    run_seq(5);
    // randomized mix of correct successors and arbitrary patterns
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 8) run_seq(1);
      else begin
        p = $urandom_range(15);
        step(4'(p), $urandom_range(19) == 0);
      end
    end
    // saturate the error counter, then clear together with an error
    run_seq(5);
    for (int i = 0; i < 260; i++) begin
      step(4'b0000, 1'b0);
      run_seq(4);
    end
    run_seq(2);
    step(4'b1111, 1'b1);
    run_seq(5);
    step(PAT[(cur + 1) % 4], 1'b1);
    run_seq(3);
    // asynchronous reset in the middle of lock
    @(negedge clk);
    #2;
    rst = 1'b1;
    {ft, dc, ex, wb} = 4'b0000;
    clr = 1'b0;
    q.delete();
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    chk_reset("reset_held");
    rst = 1'b0;
    model_reset();
    run_seq(10);
    step(4'b0000, 1'b0);
    run_seq(3);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
